// File: rtl/rv_pkg.sv
// Shared constants and types for the register-file writeback path.
package rv_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;
endpackage

// File: rtl/rv_wb_fifo.sv
// Small synchronous FIFO for back-pressured load results.
// A pop on an empty FIFO and a push on a full FIFO are both ignored.
module rv_wb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/rv_reg_wb.sv
// Writeback port driver: merges ALU results with FIFO-buffered load results
// and tracks pending loads per register. RV_WB_BYPASS_EN adds forwarding ports.
module rv_reg_wb #(
  parameter int XLEN      = rv_pkg::XLEN,
  parameter int REG_AW    = rv_pkg::REG_AW,
  parameter int LSU_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              lsu_issue,
  input  logic [REG_AW-1:0] lsu_issue_rd,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [REG_AW-1:0] lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  output logic              rs1_pending,
  output logic              rs2_pending,
  output logic [REG_AW-1:0] rd,
  output logic [XLEN-1:0]   Rd_input,
  output logic              we
`ifdef RV_WB_BYPASS_EN
  ,
  output logic              rs1_fwd_valid,
  output logic              rs2_fwd_valid,
  output logic [XLEN-1:0]   rs1_fwd_data,
  output logic [XLEN-1:0]   rs2_fwd_data
`endif
);
  import rv_pkg::*;

  localparam int NREG = 1 << REG_AW;
  localparam int EW   = REG_AW + XLEN;
  localparam logic [REG_AW-1:0] ZERO_RD = REG_AW'(REG_ZERO);

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [EW-1:0]     fifo_head;
  logic [REG_AW-1:0] head_rd;
  logic [XLEN-1:0]   head_data;

  logic              sel_valid;
  logic [REG_AW-1:0] sel_rd;
  logic [XLEN-1:0]   sel_data;

  logic [REG_AW-1:0] rd_q, rd_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic              we_q, we_d;
  logic [NREG-1:0]   sb_q, sb_d;

  // Handshake: a load result transfers on a cycle where lsu_valid && lsu_ready.
  assign lsu_ready = !fifo_full && !rst;
  assign fifo_push = lsu_valid && lsu_ready;
  assign fifo_pop  = !alu_valid && !fifo_empty;
  assign head_rd   = fifo_head[EW-1:XLEN];
  assign head_data = fifo_head[XLEN-1:0];

  rv_wb_fifo #(.W(EW), .DEPTH(LSU_DEPTH)) u_lsu_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .data_i  ({lsu_rd, lsu_data}),
    .pop_i   (fifo_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  // ALU cannot stall, so it always wins the single write port.
  always_comb begin
    sel_valid = alu_valid || !fifo_empty;
    sel_rd    = alu_valid ? alu_rd : head_rd;
    sel_data  = alu_valid ? alu_data : head_data;
    we_d      = sel_valid && (sel_rd != ZERO_RD);
    rd_d      = sel_valid ? sel_rd : rd_q;
    data_d    = sel_valid ? sel_data : data_q;
  end

  // A newer issue to the same register outlives the writeback of the older load.
  always_comb begin
    sb_d = sb_q;
    if (fifo_pop) sb_d[head_rd] = 1'b0;
    if (lsu_issue && (lsu_issue_rd != ZERO_RD)) sb_d[lsu_issue_rd] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q   <= '0;
      data_q <= '0;
      we_q   <= 1'b0;
      sb_q   <= '0;
    end else begin
      rd_q   <= rd_d;
      data_q <= data_d;
      we_q   <= we_d;
      sb_q   <= sb_d;
    end
  end

  assign rd          = rd_q;
  assign Rd_input    = data_q;
  assign we          = we_q;
  assign rs1_pending = sb_q[rs1];
  assign rs2_pending = sb_q[rs2];

`ifdef RV_WB_BYPASS_EN
  assign rs1_fwd_valid = we_q && (rd_q == rs1) && (rs1 != ZERO_RD);
  assign rs2_fwd_valid = we_q && (rd_q == rs2) && (rs2 != ZERO_RD);
  assign rs1_fwd_data  = data_q;
  assign rs2_fwd_data  = data_q;
`endif
endmodule
